// File: rtl/clk_wiz_pkg.sv
// Shared types, default constants and helpers for the clk_wiz clock-generation emulation block.
package clk_wiz_pkg;

  localparam int DIV_W       = 8;
  localparam int DIV_RESET   = 1;
  localparam int LOCK_CYCLES = 64;

  typedef enum logic [0:0] {
    ACQUIRE = 1'b0,
    LOCKED  = 1'b1
  } lock_state_e;

  // A requested ratio of 0 behaves exactly like a ratio of 1.
  function automatic logic [31:0] norm_div(input logic [31:0] d);
    if (d == 32'd0) begin
      return 32'd1;
    end else begin
      return d;
    end
  endfunction

endpackage

// File: rtl/clk_wiz_if.sv
// Ratio request and clock/lock status bundle between clk_wiz and its consumer.
interface clk_wiz_if #(
  parameter int DIV_W = clk_wiz_pkg::DIV_W
);

  logic [DIV_W-1:0] div_sel;
  logic             clk_out1;
  logic             clk_ce;
  logic             locked;
  logic [7:0]       relock_cnt;

  modport master (
    output div_sel,
    input  clk_out1,
    input  clk_ce,
    input  locked,
    input  relock_cnt
  );

  modport slave (
    input  div_sel,
    output clk_out1,
    output clk_ce,
    output locked,
    output relock_cnt
  );

endinterface

// File: rtl/clk_wiz_lock_timer.sv
// Lock acquisition model: counts LOCK_CYCLES reference edges in ACQUIRE, then holds LOCKED
// until a restart request; a restart always wins over lock completion on the same edge.
module clk_wiz_lock_timer #(
  parameter int LOCK_CYCLES = clk_wiz_pkg::LOCK_CYCLES
) (
  input  logic spi_clk,
  input  logic sys_rst,
  input  logic i_restart,
  output logic o_locked
);

  import clk_wiz_pkg::*;

  localparam int              CNT_W    = $clog2(LOCK_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(LOCK_CYCLES - 1);

  lock_state_e      r_state;
  lock_state_e      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_locked;

  // State, counter and registered lock flag.
  always_ff @(posedge spi_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state  <= ACQUIRE;
      r_cnt    <= '0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_locked <= (w_state_nxt == LOCKED);
    end
  end

  // Next-state and next-count decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ACQUIRE: begin
        if (i_restart) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == CNT_TERM) begin
          w_state_nxt = LOCKED;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      LOCKED: begin
        if (i_restart) begin
          w_state_nxt = ACQUIRE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = CNT_TERM;
        end
      end
      default: begin
        w_state_nxt = ACQUIRE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_locked = r_locked;

endmodule

// File: rtl/clk_wiz.sv
// Reference-clock divider with modelled lock acquisition and forced relock on ratio change.
// Define CLK_WIZ_GATE_UNTIL_LOCK_EN to hold the divider output low until locked.
module clk_wiz #(
  parameter int DIV_W       = clk_wiz_pkg::DIV_W,
  parameter int DIV_RESET   = clk_wiz_pkg::DIV_RESET,
  parameter int LOCK_CYCLES = clk_wiz_pkg::LOCK_CYCLES
) (
  input  logic        spi_clk,
  input  logic        sys_rst,
  clk_wiz_if.slave    bus
);

  import clk_wiz_pkg::*;

  logic [DIV_W-1:0] w_div_req;
  logic [DIV_W-1:0] w_div_last;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_phase;
  logic             w_change;
  logic             w_locked;
  logic             w_run;
  logic             r_clk;
  logic             r_ce;
  logic [7:0]       r_relock;

  assign w_div_req  = DIV_W'(norm_div(32'(bus.div_sel)));
  assign w_change   = (w_div_req != r_div);
  assign w_div_last = r_div - DIV_W'(1);

`ifdef CLK_WIZ_GATE_UNTIL_LOCK_EN
  assign w_run = w_locked;
`else
  assign w_run = 1'b1;
`endif

  // Active divide ratio; the first edge after reset compares against DIV_RESET.
  always_ff @(posedge spi_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_div <= DIV_W'(DIV_RESET);
    end else if (w_change) begin
      r_div <= w_div_req;
    end else begin
      r_div <= r_div;
    end
  end

  // Phase counter and output clock; clk_ce marks only the 0->1 toggle.
  always_ff @(posedge spi_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_phase <= '0;
      r_clk   <= 1'b0;
      r_ce    <= 1'b0;
    end else if (w_change || !w_run) begin
      r_phase <= '0;
      r_clk   <= 1'b0;
      r_ce    <= 1'b0;
    end else if (r_phase == w_div_last) begin
      r_phase <= '0;
      r_clk   <= ~r_clk;
      r_ce    <= ~r_clk;
    end else begin
      r_phase <= r_phase + DIV_W'(1);
      r_clk   <= r_clk;
      r_ce    <= 1'b0;
    end
  end

  // Saturating count of ratio-change relocks.
  always_ff @(posedge spi_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_relock <= 8'd0;
    end else if (w_change && (r_relock != 8'hFF)) begin
      r_relock <= r_relock + 8'd1;
    end else begin
      r_relock <= r_relock;
    end
  end

  clk_wiz_lock_timer #(
    .LOCK_CYCLES (LOCK_CYCLES)
  ) u_lock_timer (
    .spi_clk   (spi_clk),
    .sys_rst   (sys_rst),
    .i_restart (w_change),
    .o_locked  (w_locked)
  );

  assign bus.clk_out1   = r_clk;
  assign bus.clk_ce     = r_ce;
  assign bus.locked     = w_locked;
  assign bus.relock_cnt = r_relock;

endmodule

// File: tb/tb_clk_wiz.sv
// Directed self-checking bench for clk_wiz: lock timing, divider waveform, relock counting,
// asynchronous reset and saturation, with expectations derived from the block's timing rules.
module tb_clk_wiz;

  localparam int LOCK = 64;
`ifdef CLK_WIZ_GATE_UNTIL_LOCK_EN
  localparam bit GATED = 1'b1;
`else
  localparam bit GATED = 1'b0;
`endif

  logic spi_clk;
  logic sys_rst;
  int   n_tests;
  int   n_fail;

  clk_wiz_if #(.DIV_W(8)) bus ();

  clk_wiz u_dut (
    .spi_clk (spi_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  initial spi_clk = 1'b0;
  always #5 spi_clk = ~spi_clk;

  // j = edges since the phase counter was last cleared; lj = edge at which lock rose.
  function automatic logic exp_clk(input int j, input int d, input int lj);
    int m;
    m = GATED ? (j - lj) : j;
    if (m <= 0) return 1'b0;
    return ((m / d) % 2) == 1;
  endfunction

  function automatic logic exp_ce(input int j, input int d, input int lj);
    int m;
    m = GATED ? (j - lj) : j;
    if (m <= 0) return 1'b0;
    return (m % (2 * d)) == d;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge spi_clk);
    @(negedge spi_clk);
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    sys_rst     = 1'b1;
    bus.div_sel = 8'd1;
    repeat (3) @(negedge spi_clk);
    check("rst_clk",    32'(bus.clk_out1),   32'd0);
    check("rst_ce",     32'(bus.clk_ce),     32'd0);
    check("rst_locked", 32'(bus.locked),     32'd0);
    check("rst_relock", 32'(bus.relock_cnt), 32'd0);

    // D=1 from reset: toggle every edge, lock after edge 64
    sys_rst = 1'b0;
    for (int e = 1; e <= LOCK; e++) begin
      tick();
      check("d1_clk",    32'(bus.clk_out1), 32'(exp_clk(e, 1, LOCK)));
      check("d1_ce",     32'(bus.clk_ce),   32'(exp_ce(e, 1, LOCK)));
      check("d1_locked", 32'(bus.locked),   32'(e >= LOCK));
    end
    check("d1_relock", 32'(bus.relock_cnt), 32'd0);

    // Ratio change to 3 while locked
    bus.div_sel = 8'd3;
    tick();
    check("d3_drop_locked", 32'(bus.locked),     32'd0);
    check("d3_drop_clk",    32'(bus.clk_out1),   32'd0);
    check("d3_drop_ce",     32'(bus.clk_ce),     32'd0);
    check("d3_relock",      32'(bus.relock_cnt), 32'd1);
    for (int j = 1; j <= LOCK; j++) begin
      tick();
      check("d3_clk",    32'(bus.clk_out1), 32'(exp_clk(j, 3, LOCK)));
      check("d3_ce",     32'(bus.clk_ce),   32'(exp_ce(j, 3, LOCK)));
      check("d3_locked", 32'(bus.locked),   32'(j >= LOCK));
    end

    // Ratio 0 behaves as 1; switching between 0 and 1 is not a change
    bus.div_sel = 8'd0;
    tick();
    check("d0_relock", 32'(bus.relock_cnt), 32'd2);
    check("d0_locked", 32'(bus.locked),     32'd0);
    for (int j = 1; j <= LOCK; j++) begin
      tick();
      check("d0_clk",       32'(bus.clk_out1), 32'(exp_clk(j, 1, LOCK)));
      check("d0_locked_lp", 32'(bus.locked),   32'(j >= LOCK));
    end
    bus.div_sel = 8'd1;
    for (int j = LOCK + 1; j <= LOCK + 6; j++) begin
      tick();
      check("d01_clk",    32'(bus.clk_out1),   32'(exp_clk(j, 1, LOCK)));
      check("d01_locked", 32'(bus.locked),     32'd1);
      check("d01_relock", 32'(bus.relock_cnt), 32'd2);
    end

    // Asynchronous reset mid-acquire
    bus.div_sel = 8'd2;
    tick();
    check("d2_relock", 32'(bus.relock_cnt), 32'd3);
    for (int j = 1; j <= 10; j++) tick();
    check("pre_rst_clk", 32'(bus.clk_out1), 32'(exp_clk(10, 2, LOCK)));
    #2;
    sys_rst     = 1'b1;
    bus.div_sel = 8'd1;
    #1;
    check("arst_clk",    32'(bus.clk_out1),   32'd0);
    check("arst_ce",     32'(bus.clk_ce),     32'd0);
    check("arst_locked", 32'(bus.locked),     32'd0);
    check("arst_relock", 32'(bus.relock_cnt), 32'd0);
    @(negedge spi_clk);
    sys_rst = 1'b0;
    for (int e = 1; e <= LOCK; e++) begin
      tick();
      check("relock_full", 32'(bus.locked), 32'(e >= LOCK));
    end
    check("post_rst_relock", 32'(bus.relock_cnt), 32'd0);

    // Continuous alternating ratio changes saturate the relock counter
    for (int i = 1; i <= 260; i++) begin
      bus.div_sel = (i % 2 == 1) ? 8'd2 : 8'd3;
      tick();
      check("sat_locked", 32'(bus.locked), 32'd0);
      if (i == 254) check("sat_254", 32'(bus.relock_cnt), 32'd254);
    end
    check("sat_255", 32'(bus.relock_cnt), 32'd255);

    // D=2 through lock; gated builds start the divider only after lock
    bus.div_sel = 8'd2;
    tick();
    check("sat_hold", 32'(bus.relock_cnt), 32'd255);
    for (int j = 1; j <= LOCK + 8; j++) begin
      tick();
      check("g2_clk",    32'(bus.clk_out1), 32'(exp_clk(j, 2, LOCK)));
      check("g2_ce",     32'(bus.clk_ce),   32'(exp_ce(j, 2, LOCK)));
      check("g2_locked", 32'(bus.locked),   32'(j >= LOCK));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
